// File: rtl/baser_pkg.sv
// Shared 64B/66B transmit definitions: MII characters, 7-bit control codes,
// sync headers, block types, encoder state/class enums and small helpers.
package baser_pkg;

    localparam int unsigned MII_DATA_W = 64;
    localparam int unsigned MII_CTRL_W = MII_DATA_W / 8;
    localparam int unsigned SYNC_W     = 2;
    localparam int unsigned BLOCK_W    = MII_DATA_W + SYNC_W;

    localparam logic [7:0] MII_IDLE  = 8'h07;
    localparam logic [7:0] MII_ERROR = 8'hFE;
    localparam logic [7:0] MII_START = 8'hFB;
    localparam logic [7:0] MII_TERM  = 8'hFD;
    localparam logic [7:0] MII_SEQ   = 8'h9C;

    localparam logic [6:0] CODE_IDLE  = 7'h00;
    localparam logic [6:0] CODE_ERROR = 7'h1E;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

    localparam logic [7:0] BT_CTRL  = 8'h1E;
    localparam logic [7:0] BT_OSET  = 8'h4B;
    localparam logic [7:0] BT_START = 8'h78;

    // Error block: control type with every lane carrying the error code
    localparam logic [BLOCK_W-1:0] EBLOCK_T = {{8{CODE_ERROR}}, BT_CTRL, SYNC_CTRL};

    typedef enum logic [2:0] {TX_INIT, TX_C, TX_D, TX_T, TX_E} tx_state_t;
    typedef enum logic [2:0] {C, S, T, D, E} blk_class_t;

    // True for the only control characters a control lane may carry
    function automatic logic is_ctrl_char(input logic [7:0] b);
        return (b == MII_IDLE) || (b == MII_ERROR);
    endfunction

    function automatic logic [6:0] ctrl_code(input logic [7:0] b);
        return (b == MII_IDLE) ? CODE_IDLE : CODE_ERROR;
    endfunction

    // All lanes above lane k hold idle/error characters
    function automatic logic tail_is_ctrl(input logic [MII_DATA_W-1:0] txd, input int k);
        logic ok;
        ok = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if (j > k && !is_ctrl_char(txd[8*j +: 8])) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [7:0] term_type(input logic [2:0] k);
        logic [7:0] t;
        case (k)
            3'd0:    t = 8'h87;
            3'd1:    t = 8'h99;
            3'd2:    t = 8'hAA;
            3'd3:    t = 8'hB4;
            3'd4:    t = 8'hCC;
            3'd5:    t = 8'hD2;
            3'd6:    t = 8'hE1;
            default: t = 8'hFF;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/baser_66b_block_encoder.sv
// Combinational 64B/66B block encoder: classifies one MII word and builds its 66b block.
//   i_txd      MII data, lane k = i_txd[8k+:8]
//   i_txc      MII control, bit k flags lane k
//   o_block_c  encoded block, sync header in [1:0], type in [9:2]
//   o_class_c  word class (C/S/T/D/E)
module baser_66b_block_encoder
    import baser_pkg::*;
(
    input  logic [MII_DATA_W-1:0] i_txd,
    input  logic [MII_CTRL_W-1:0] i_txc,
    output logic [BLOCK_W-1:0]    o_block_c,
    output blk_class_t            o_class_c
);

    logic       w_all_ctrl;
    logic       w_term_hit;
    logic [2:0] w_term_k;

    // Detect an all-control word and locate a terminate in any lane
    always_comb begin
        w_all_ctrl = (i_txc == 8'hFF);
        for (int j = 0; j < 8; j++) begin
            if (!is_ctrl_char(i_txd[8*j +: 8])) w_all_ctrl = 1'b0;
        end
        w_term_hit = 1'b0;
        w_term_k   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (i_txc == 8'(8'hFF << k) && i_txd[8*k +: 8] == MII_TERM && tail_is_ctrl(i_txd, k)) begin
                w_term_hit = 1'b1;
                w_term_k   = 3'(k);
            end
        end
    end

    // Control lane j always lands at [10+7j]; terminate pad bits stay zero from the default
    always_comb begin
        o_block_c = '0;
        o_class_c = E;
        if (i_txc == 8'h00) begin
            o_class_c = D;
            o_block_c = {i_txd, SYNC_DATA};
        end else if (w_all_ctrl) begin
            o_class_c      = C;
            o_block_c[1:0] = SYNC_CTRL;
            o_block_c[9:2] = BT_CTRL;
            for (int j = 0; j < 8; j++) begin
                o_block_c[10 + 7*j +: 7] = ctrl_code(i_txd[8*j +: 8]);
            end
        end else if (i_txc == 8'hF1 && i_txd[7:0] == MII_SEQ) begin
            o_class_c        = C;
            o_block_c[1:0]   = SYNC_CTRL;
            o_block_c[9:2]   = BT_OSET;
            o_block_c[33:10] = i_txd[31:8];
        end else if (i_txc == 8'h01 && i_txd[7:0] == MII_START) begin
            o_class_c        = S;
            o_block_c[1:0]   = SYNC_CTRL;
            o_block_c[9:2]   = BT_START;
            o_block_c[65:10] = i_txd[63:8];
        end else if (w_term_hit) begin
            o_class_c      = T;
            o_block_c[1:0] = SYNC_CTRL;
            o_block_c[9:2] = term_type(w_term_k);
            for (int j = 0; j < 7; j++) begin
                if (j < int'(w_term_k)) o_block_c[10 + 8*j +: 8] = i_txd[8*j +: 8];
            end
            for (int j = 0; j < 8; j++) begin
                if (j > int'(w_term_k)) o_block_c[10 + 7*j +: 7] = ctrl_code(i_txd[8*j +: 8]);
            end
        end
    end

endmodule

// File: rtl/mii_66b_encoder_x4.sv
// 1.6TMII to 64B/66B transmit encoder; packs every 4 encoded blocks into one bundle.
//   clk, i_rst                 clock and synchronous active-high reset
//   i_txd, i_txc, i_valid      MII word, accepted when i_valid is high
//   o_tx_coded_0..3            bundle, _0 oldest block
//   o_valid                    one-cycle pulse when a bundle is loaded
//   o_*_count                  block / data / control / error-block counters (mod 2^32)
module mii_66b_encoder_x4
    import baser_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned CTRL_WIDTH  = DATA_WIDTH / 8,
    parameter int unsigned HDR_WIDTH   = 2,
    parameter int unsigned FRAME_WIDTH = DATA_WIDTH + HDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic [DATA_WIDTH-1:0]  i_txd,
    input  logic [CTRL_WIDTH-1:0]  i_txc,
    input  logic                   i_valid,
    output logic [FRAME_WIDTH-1:0] o_tx_coded_0,
    output logic [FRAME_WIDTH-1:0] o_tx_coded_1,
    output logic [FRAME_WIDTH-1:0] o_tx_coded_2,
    output logic [FRAME_WIDTH-1:0] o_tx_coded_3,
    output logic                   o_valid,
    output logic [31:0]            o_block_count,
    output logic [31:0]            o_data_count,
    output logic [31:0]            o_ctrl_count,
    output logic [31:0]            o_err_block_count
);

    logic [FRAME_WIDTH-1:0] w_enc_block;
    blk_class_t             w_enc_class;
    tx_state_t              w_next_state;
    logic                   w_is_eblock;
    logic [FRAME_WIDTH-1:0] w_tx_block;

    tx_state_t              r_state;
    logic [1:0]             r_slot;
    logic [FRAME_WIDTH-1:0] r_stage0, r_stage1, r_stage2;

    baser_66b_block_encoder u_enc (
        .i_txd     (i_txd),
        .i_txc     (i_txc),
        .o_block_c (w_enc_block),
        .o_class_c (w_enc_class)
    );

    // TX state transitions; anything not listed falls into TX_E
    always_comb begin
        w_next_state = TX_E;
        case (r_state)
            TX_INIT, TX_C, TX_T: begin
                if (w_enc_class == C)      w_next_state = TX_C;
                else if (w_enc_class == S) w_next_state = TX_D;
            end
            TX_D: begin
                if (w_enc_class == D)      w_next_state = TX_D;
                else if (w_enc_class == T) w_next_state = TX_T;
            end
            TX_E: begin
                if (w_enc_class == D)      w_next_state = TX_D;
                else if (w_enc_class == T) w_next_state = TX_T;
                else if (w_enc_class == C) w_next_state = TX_C;
            end
            default: w_next_state = TX_E;
        endcase
    end

    assign w_is_eblock = (w_next_state == TX_E);
    assign w_tx_block  = w_is_eblock ? EBLOCK_T : w_enc_block;

    // State, slot staging, bundle load and counters; everything holds while i_valid is low
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state           <= TX_INIT;
            r_slot            <= 2'd0;
            r_stage0          <= '0;
            r_stage1          <= '0;
            r_stage2          <= '0;
            o_tx_coded_0      <= '0;
            o_tx_coded_1      <= '0;
            o_tx_coded_2      <= '0;
            o_tx_coded_3      <= '0;
            o_valid           <= 1'b0;
            o_block_count     <= '0;
            o_data_count      <= '0;
            o_ctrl_count      <= '0;
            o_err_block_count <= '0;
        end else begin
            o_valid <= 1'b0;
            if (i_valid) begin
                r_state       <= w_next_state;
                r_slot        <= r_slot + 2'd1;
                o_block_count <= o_block_count + 32'd1;
                if (w_tx_block[1:0] == SYNC_DATA) o_data_count <= o_data_count + 32'd1;
                else                              o_ctrl_count <= o_ctrl_count + 32'd1;
                if (w_is_eblock) o_err_block_count <= o_err_block_count + 32'd1;
                case (r_slot)
                    2'd0: r_stage0 <= w_tx_block;
                    2'd1: r_stage1 <= w_tx_block;
                    2'd2: r_stage2 <= w_tx_block;
                    default: begin
                        o_tx_coded_0 <= r_stage0;
                        o_tx_coded_1 <= r_stage1;
                        o_tx_coded_2 <= r_stage2;
                        o_tx_coded_3 <= w_tx_block;
                        o_valid      <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
